// File: rtl/quality_sensor_conditioner_pkg.sv
// Shared definitions for the sensor conditioner: state encoding, channel
// indices and default widths/thresholds (also used by the grading FSM bench).
package quality_sensor_conditioner_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int AVG_LOG2_DEF   = 2;
  localparam int WEIGHT_MIN_DEF = 100;
  localparam int WEIGHT_MAX_DEF = 200;
  localparam int SIZE_MIN_DEF   = 50;
  localparam int COLOR_MIN_DEF  = 128;

  localparam int NUM_CH    = 3;
  localparam int CH_WEIGHT = 0;
  localparam int CH_SIZE   = 1;
  localparam int CH_COLOR  = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ACCUM   = ST_ACCUM,
    COMPARE = ST_COMPARE
  } state_t;

endpackage

// File: rtl/quality_sensor_conditioner_if.sv
// Sample/verdict bus between the sensor front end and the grading FSM side.
interface quality_sensor_conditioner_if #(
  parameter int DATA_W = 8
);
  logic              sample_valid_i;
  logic              sample_ready_o;
  logic [DATA_W-1:0] weight_i;
  logic [DATA_W-1:0] size_i;
  logic [DATA_W-1:0] color_i;
  logic              clear_i;
  logic              weight_ok_o;
  logic              size_ok_o;
  logic              color_ok_o;
  logic              result_valid_o;
  logic              busy_o;

  // Producer of samples / consumer of verdicts
  modport master (
    output sample_valid_i, weight_i, size_i, color_i, clear_i,
    input  sample_ready_o, weight_ok_o, size_ok_o, color_ok_o,
           result_valid_o, busy_o
  );

  // The conditioner itself
  modport slave (
    input  sample_valid_i, weight_i, size_i, color_i, clear_i,
    output sample_ready_o, weight_ok_o, size_ok_o, color_ok_o,
           result_valid_o, busy_o
  );
endinterface

// File: rtl/quality_sensor_conditioner_channel_accumulator.sv
// One sensor channel: load/add/clear accumulator. Exposes the average of the
// value the accumulator is about to take, so the verdict can be registered
// on the same edge that accepts the last sample of a window.
module channel_accumulator #(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] avg_nxt_o
);
  // Extra AVG_LOG2 bits hold N full-scale samples without wrapping
  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_nxt;

  // Next sum: fresh load starts a window, otherwise add onto the running sum
  always_comb begin
    acc_nxt = load_i ? ACC_W'(din_i) : acc_q + ACC_W'(din_i);
  end

  assign avg_nxt_o = DATA_W'(acc_nxt >> AVG_LOG2);

  // Accumulator register; clear has priority over load/add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               acc_q <= '0;
    else if (clr_i)           acc_q <= '0;
    else if (load_i || add_i) acc_q <= acc_nxt;
  end
endmodule

// File: rtl/quality_sensor_conditioner.sv
// Averages weight/size/colour readings over 2^AVG_LOG2 accepted samples and
// registers threshold verdicts for the grading FSM.
module quality_sensor_conditioner
  import quality_sensor_conditioner_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int AVG_LOG2   = AVG_LOG2_DEF,
  parameter int WEIGHT_MIN = WEIGHT_MIN_DEF,
  parameter int WEIGHT_MAX = WEIGHT_MAX_DEF,
  parameter int SIZE_MIN   = SIZE_MIN_DEF,
  parameter int COLOR_MIN  = COLOR_MIN_DEF
) (
  input logic                          clk,
  input logic                          rst_n,
  quality_sensor_conditioner_if.slave  bus
);
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int N     = 1 << AVG_LOG2;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);
  localparam logic [DATA_W-1:0] W_MIN    = DATA_W'(WEIGHT_MIN);
  localparam logic [DATA_W-1:0] W_MAX    = DATA_W'(WEIGHT_MAX);
  localparam logic [DATA_W-1:0] S_MIN    = DATA_W'(SIZE_MIN);
  localparam logic [DATA_W-1:0] C_MIN    = DATA_W'(COLOR_MIN);

  state_t                           state;
  logic [CNT_W-1:0]                 cnt;
  logic [NUM_CH-1:0]                ok_q;
  logic [NUM_CH-1:0]                ok_nxt;
  logic                             rv_q;
  logic [NUM_CH-1:0][DATA_W-1:0]    din;
  logic [NUM_CH-1:0][DATA_W-1:0]    avg_nxt;
  logic                             accept;
  logic                             last;
  logic                             acc_clr;
  logic                             acc_load;
  logic                             acc_add;

  assign din[CH_WEIGHT] = bus.weight_i;
  assign din[CH_SIZE]   = bus.size_i;
  assign din[CH_COLOR]  = bus.color_i;

  assign bus.sample_ready_o = (state == IDLE) || (state == ACCUM);
  assign accept             = bus.sample_valid_i && bus.sample_ready_o;

  // Sample that completes the window (first sample already completes it when N == 1)
  assign last = ((state == IDLE) && (AVG_LOG2 == 0)) ||
                ((state == ACCUM) && (cnt == CNT_LAST));

  // Accumulators zero on abort, in COMPARE (window done) and in any illegal state
  assign acc_clr  = bus.clear_i || !((state == IDLE) || (state == ACCUM));
  assign acc_load = !bus.clear_i && (state == IDLE)  && accept;
  assign acc_add  = !bus.clear_i && (state == ACCUM) && accept;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    channel_accumulator #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (acc_clr),
      .load_i    (acc_load),
      .add_i     (acc_add),
      .din_i     (din[g]),
      .avg_nxt_o (avg_nxt[g])
    );
  end

  // Unsigned, inclusive threshold checks on the window averages
  always_comb begin
    ok_nxt            = '0;
    ok_nxt[CH_WEIGHT] = (avg_nxt[CH_WEIGHT] >= W_MIN) && (avg_nxt[CH_WEIGHT] <= W_MAX);
    ok_nxt[CH_SIZE]   = (avg_nxt[CH_SIZE]   >= S_MIN);
    ok_nxt[CH_COLOR]  = (avg_nxt[CH_COLOR]  >= C_MIN);
  end

  // Control FSM. Verdict flags are captured on the edge that accepts the Nth
  // sample, so they and result_valid are visible during the single COMPARE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ok_q  <= '0;
      rv_q  <= 1'b0;
    end else if (bus.clear_i) begin
      state <= IDLE;
      cnt   <= '0;
      ok_q  <= '0;
      rv_q  <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      if (accept && last) begin
        ok_q <= ok_nxt;
        rv_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= CNT_W'(1);
            state <= last ? COMPARE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (last) state <= COMPARE;
          end
        end
        COMPARE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.weight_ok_o    = ok_q[CH_WEIGHT];
  assign bus.size_ok_o      = ok_q[CH_SIZE];
  assign bus.color_ok_o     = ok_q[CH_COLOR];
  // An abort during COMPARE suppresses the pulse in that same cycle
  assign bus.result_valid_o = rv_q && !bus.clear_i;
  assign bus.busy_o         = (state != IDLE);

endmodule

// File: tb/tb_quality_sensor_conditioner.sv
// Directed bench for quality_sensor_conditioner with N = 4 and default thresholds.
module tb_quality_sensor_conditioner;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  quality_sensor_conditioner_if #(.DATA_W(8)) bus ();

  quality_sensor_conditioner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] w, input logic [7:0] s, input logic [7:0] c);
    bus.sample_valid_i = 1'b1;
    bus.weight_i       = w;
    bus.size_i         = s;
    bus.color_i        = c;
  endtask

  function automatic logic [2:0] flags();
    return {bus.weight_ok_o, bus.size_ok_o, bus.color_ok_o};
  endfunction

  // Four consecutive samples; leaves the bench in the COMPARE cycle
  task automatic run4(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                      input logic [7:0] w2, input logic [7:0] w3,
                      input logic [7:0] s, input logic [7:0] c);
    drive(w0, s, c); tick();
    chk({tag, "_rv_early"}, bus.result_valid_o, 1'b0);
    drive(w1, s, c); tick();
    drive(w2, s, c); tick();
    drive(w3, s, c); tick();
    bus.sample_valid_i = 1'b0;
  endtask

  task automatic verdict(input string tag, input logic [2:0] exp_flags);
    chk({tag, "_rv"},    bus.result_valid_o, 1'b1);
    chk({tag, "_flags"}, flags(), exp_flags);
    tick();
    chk({tag, "_rv_off"}, bus.result_valid_o, 1'b0);
  endtask

  initial begin
    int pulses, rdy_low, p1, p2;
    logic last_w;

    rst_n              = 1'b0;
    bus.sample_valid_i = 1'b0;
    bus.clear_i        = 1'b0;
    bus.weight_i       = '0;
    bus.size_i         = '0;
    bus.color_i        = '0;
    #3;
    chk("rst_ready", bus.sample_ready_o, 1'b1);
    chk("rst_busy",  bus.busy_o, 1'b0);
    chk("rst_rv",    bus.result_valid_o, 1'b0);
    chk("rst_flags", flags(), 3'b000);
    #9 rst_n = 1'b1;
    tick();

    // Nominal window, verdict one cycle after 4th sample, then holds
    run4("nom", 150, 150, 150, 150, 60, 200);
    chk("nom_ready_cmp", bus.sample_ready_o, 1'b0);
    chk("nom_busy_cmp",  bus.busy_o, 1'b1);
    verdict("nom", 3'b111);
    tick(); tick();
    chk("nom_hold",  flags(), 3'b111);
    chk("nom_idle",  bus.busy_o, 1'b0);

    // Boundaries
    run4("wlo_ok",  99, 100, 100, 101, 50, 128);  verdict("wlo_ok",  3'b111);
    run4("wlo_bad", 99,  99,  99, 100, 49, 127);  verdict("wlo_bad", 3'b000);
    run4("whi_ok",  200, 200, 200, 200, 60, 200); verdict("whi_ok",  3'b111);
    run4("whi_bad", 201, 201, 201, 201, 60, 200); verdict("whi_bad", 3'b011);
    run4("sat",     255, 255, 255, 255, 255, 255); verdict("sat",    3'b011);

    // Abort mid-window
    drive(10, 10, 10); tick();
    drive(10, 10, 10); tick();
    chk("clr_busy_pre", bus.busy_o, 1'b1);
    bus.sample_valid_i = 1'b0;
    bus.clear_i        = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    chk("clr_flags", flags(), 3'b000);
    chk("clr_busy",  bus.busy_o, 1'b0);
    chk("clr_rv",    bus.result_valid_o, 1'b0);
    run4("clr_after", 150, 150, 150, 150, 60, 200);
    verdict("clr_after", 3'b111);

    // Streaming: valid high 10 cycles; samples at COMPARE (k=5,10) are dropped
    pulses = 0; rdy_low = 0; p1 = 0; p2 = 0; last_w = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      drive(((k == 5) || (k == 10)) ? 8'd0 : 8'd100, 60, 200);
      tick();
      if (!bus.sample_ready_o) rdy_low++;
      if (bus.result_valid_o) begin
        pulses++;
        if (pulses == 1) p1 = k; else p2 = k;
        last_w = bus.weight_ok_o;
      end
    end
    bus.sample_valid_i = 1'b0;
    chk("stream_pulses",  pulses, 2);
    chk("stream_rdy_low", rdy_low, 2);
    chk("stream_p1",      p1, 4);
    chk("stream_p2",      p2, 9);
    chk("stream_w_ok",    last_w, 1'b1);
    tick();

    // Asynchronous reset between edges while accumulating
    drive(10, 10, 10); tick();
    drive(10, 10, 10); tick();
    bus.sample_valid_i = 1'b0;
    chk("ar_flags_pre", flags(), 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_flags", flags(), 3'b000);
    chk("ar_busy",  bus.busy_o, 1'b0);
    chk("ar_rv",    bus.result_valid_o, 1'b0);
    chk("ar_ready", bus.sample_ready_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run4("ar_after", 150, 150, 150, 150, 60, 200);
    verdict("ar_after", 3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
